// File: rtl/minmem_pkg.sv
// Shared constants and FSM state type for the minimal-memory copy initiator.
package minmem_pkg;

  localparam int DATA_W      = 32;
  localparam int SIZE_W      = 6;
  localparam int CH_RD       = 0;
  localparam int CH_WR       = 1;
  localparam int ADDR_STRIDE = 4;

  localparam logic [SIZE_W-1:0] WORD_SIZE_BITS = 6'd32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/minmem_fifo2.sv
// Small synchronous FIFO decoupling the read channel from the write channel.
module minmem_fifo2
  import minmem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/minmem_copy_initiator.sv
// Bus-master copy engine: channel 0 reads, channel 1 writes, overlapped through a small buffer.
// Define CHECKSUM_EN to add a running 32-bit sum of all written words on port checksum.
module minmem_copy_initiator
  import minmem_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int LEN_W     = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_port,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [LEN_W-1:0]      n_words,
  output logic                  done_port,
  output logic                  busy,
  output logic [LEN_W-1:0]      words_done,
`ifdef CHECKSUM_EN
  output logic [DATA_W-1:0]     checksum,
`endif
  output logic [1:0]            Mout_oe_ram,
  output logic [1:0]            Mout_we_ram,
  output logic [2*ADDR_W-1:0]   Mout_addr_ram,
  output logic [63:0]           Mout_Wdata_ram,
  output logic [2*SIZE_W-1:0]   Mout_data_ram_size,
  input  logic [63:0]           M_Rdata_ram,
  input  logic [1:0]            M_DataRdy
);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   wr_addr;
  logic [LEN_W-1:0]    n_reg;
  logic [LEN_W-1:0]    rd_cnt;
  logic                accept;
  logic                rd_en;
  logic                wr_en;
  logic                rd_ack;
  logic                wr_ack;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_head;
  logic                unused_rdata_hi;

  assign unused_rdata_hi = ^M_Rdata_ram[63:DATA_W];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A read is only offered while a buffer slot is free, so oe stays up until its ack.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done_port  = 1'b0;
    case (state)
      IDLE: begin
        if (start_port) begin
          accept     = 1'b1;
          state_next = (n_words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        rd_en = (rd_cnt < n_reg) && !fifo_full;
        wr_en = !fifo_empty;
        if (wr_en && M_DataRdy[CH_WR] && (words_done == n_reg - LEN_W'(1)))
          state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done_port  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_ack = rd_en && M_DataRdy[CH_RD];
  assign wr_ack = wr_en && M_DataRdy[CH_WR];

  always_comb begin
    Mout_oe_ram        = '0;
    Mout_we_ram        = '0;
    Mout_oe_ram[CH_RD] = rd_en;
    Mout_we_ram[CH_WR] = wr_en;
    Mout_addr_ram      = {wr_en ? wr_addr : {ADDR_W{1'b0}},
                          rd_en ? rd_addr : {ADDR_W{1'b0}}};
    Mout_Wdata_ram     = {wr_en ? fifo_head : {DATA_W{1'b0}}, {DATA_W{1'b0}}};
    Mout_data_ram_size = {wr_en ? WORD_SIZE_BITS : {SIZE_W{1'b0}},
                          rd_en ? WORD_SIZE_BITS : {SIZE_W{1'b0}}};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr    <= '0;
      wr_addr    <= '0;
      n_reg      <= '0;
      rd_cnt     <= '0;
      words_done <= '0;
    end else begin
      if (accept) begin
        rd_addr    <= src_addr;
        wr_addr    <= dst_addr;
        n_reg      <= n_words;
        rd_cnt     <= '0;
        words_done <= '0;
      end
      if (rd_ack) begin
        rd_addr <= rd_addr + ADDR_W'(ADDR_STRIDE);
        rd_cnt  <= rd_cnt + LEN_W'(1);
      end
      if (wr_ack) begin
        wr_addr    <= wr_addr + ADDR_W'(ADDR_STRIDE);
        words_done <= words_done + LEN_W'(1);
      end
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset)       checksum <= '0;
    else if (accept) checksum <= '0;
    else if (wr_ack) checksum <= checksum + fifo_head;
  end
`endif

  minmem_fifo2 #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_W)
  ) u_buf (
    .clock (clock),
    .reset (reset),
    .push  (rd_ack),
    .din   (M_Rdata_ram[DATA_W-1:0]),
    .pop   (wr_ack),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_minmem_copy_initiator.sv
// Self-checking bench for minmem_copy_initiator with a delay-programmable memory responder.
// Build with CHECKSUM_EN defined to also exercise the checksum output.
module tb_minmem_copy_initiator;

  localparam int ADDR_W    = 11;
  localparam int LEN_W     = 16;
  localparam int MEM_WORDS = 512;
  localparam int LOG_MAX   = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic              start_port;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  n_words;
  logic              done_port;
  logic              busy;
  logic [LEN_W-1:0]  words_done;
`ifdef CHECKSUM_EN
  logic [31:0]       checksum;
`endif
  logic [1:0]        Mout_oe_ram;
  logic [1:0]        Mout_we_ram;
  logic [21:0]       Mout_addr_ram;
  logic [63:0]       Mout_Wdata_ram;
  logic [11:0]       Mout_data_ram_size;
  logic [63:0]       M_Rdata_ram;
  logic [1:0]        M_DataRdy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  minmem_copy_initiator dut (
    .clock              (clock),
    .reset              (reset),
    .start_port         (start_port),
    .src_addr           (src_addr),
    .dst_addr           (dst_addr),
    .n_words            (n_words),
    .done_port          (done_port),
    .busy               (busy),
    .words_done         (words_done),
`ifdef CHECKSUM_EN
    .checksum           (checksum),
`endif
    .Mout_oe_ram        (Mout_oe_ram),
    .Mout_we_ram        (Mout_we_ram),
    .Mout_addr_ram      (Mout_addr_ram),
    .Mout_Wdata_ram     (Mout_Wdata_ram),
    .Mout_data_ram_size (Mout_data_ram_size),
    .M_Rdata_ram        (M_Rdata_ram),
    .M_DataRdy          (M_DataRdy)
  );

  // Memory responder: acks a request once it has been held for the programmed delay.
  logic [31:0] rmem [MEM_WORDS];
  int rd_delay = 2, wr_delay = 1;
  int rd_hold = 0, wr_hold = 0;
  logic log_clear = 1'b0;

  assign M_Rdata_ram = {32'hA5A5_5A5A, rmem[Mout_addr_ram[10:2]]};
  assign M_DataRdy   = {Mout_we_ram[1] && (wr_hold >= wr_delay - 1),
                        Mout_oe_ram[0] && (rd_hold >= rd_delay - 1)};

  // Transaction logs and protocol monitor, all updated on the clock edge that commits a handshake.
  logic [10:0] rd_log_addr [LOG_MAX];
  logic [10:0] wr_log_addr [LOG_MAX];
  logic [31:0] wr_log_data [LOG_MAX];
  int rd_n = 0, wr_n = 0, done_cnt = 0, proto_err = 0, bus_cycles = 0;
  int occ = 0, full_seen = 0, cyc = 0, start_cyc = 0, done_cyc = 0;
  logic prev_rd_wait = 1'b0, prev_wr_wait = 1'b0;
  logic [10:0] prev_rd_addr, prev_wr_addr;
  logic [31:0] prev_wdata;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (log_clear) begin
      rd_n <= 0; wr_n <= 0; done_cnt <= 0; proto_err <= 0; bus_cycles <= 0;
      occ <= 0; full_seen <= 0; rd_hold <= 0; wr_hold <= 0;
      prev_rd_wait <= 1'b0; prev_wr_wait <= 1'b0;
    end else if (reset) begin
      rd_hold <= 0; wr_hold <= 0; occ <= 0;
      prev_rd_wait <= 1'b0; prev_wr_wait <= 1'b0;
    end else begin
      rd_hold <= (Mout_oe_ram[0] && !M_DataRdy[0]) ? rd_hold + 1 : 0;
      wr_hold <= (Mout_we_ram[1] && !M_DataRdy[1]) ? wr_hold + 1 : 0;
      if (start_port && !busy) start_cyc <= cyc;
      if (done_port) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      bus_cycles <= bus_cycles + int'(Mout_oe_ram[0]) + int'(Mout_we_ram[1]);
      if (Mout_oe_ram[0] && M_DataRdy[0]) begin
        if (rd_n < LOG_MAX) rd_log_addr[rd_n] <= Mout_addr_ram[10:0];
        rd_n <= rd_n + 1;
      end
      if (Mout_we_ram[1] && M_DataRdy[1]) begin
        if (wr_n < LOG_MAX) begin
          wr_log_addr[wr_n] <= Mout_addr_ram[21:11];
          wr_log_data[wr_n] <= Mout_Wdata_ram[63:32];
        end
        wr_n <= wr_n + 1;
      end
      occ <= occ + int'(Mout_oe_ram[0] && M_DataRdy[0]) - int'(Mout_we_ram[1] && M_DataRdy[1]);
      if (occ >= 2) full_seen <= full_seen + 1;
      if ((Mout_oe_ram[0] && occ >= 2) || Mout_oe_ram[1] || Mout_we_ram[0] ||
          (Mout_Wdata_ram[31:0] != 32'h0) ||
          (Mout_data_ram_size != {Mout_we_ram[1] ? 6'd32 : 6'd0, Mout_oe_ram[0] ? 6'd32 : 6'd0}) ||
          (prev_rd_wait && (!Mout_oe_ram[0] || Mout_addr_ram[10:0] != prev_rd_addr)) ||
          (prev_wr_wait && (!Mout_we_ram[1] || Mout_addr_ram[21:11] != prev_wr_addr ||
                            Mout_Wdata_ram[63:32] != prev_wdata)))
        proto_err <= proto_err + 1;
      prev_rd_wait <= Mout_oe_ram[0] && !M_DataRdy[0];
      prev_wr_wait <= Mout_we_ram[1] && !M_DataRdy[1];
      prev_rd_addr <= Mout_addr_ram[10:0];
      prev_wr_addr <= Mout_addr_ram[21:11];
      prev_wdata   <= Mout_Wdata_ram[63:32];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [10:0] s, input logic [10:0] d, input int n,
                               input int rdd, input int wrd);
    @(negedge clock);
    rd_delay  = rdd;
    wr_delay  = wrd;
    log_clear = 1'b1;
    @(negedge clock);
    log_clear  = 1'b0;
    src_addr   = s;
    dst_addr   = d;
    n_words    = LEN_W'(n);
    start_port = 1'b1;
    @(negedge clock);
    start_port = 1'b0;
    src_addr   = ADDR_W'($urandom);
    dst_addr   = ADDR_W'($urandom);
    n_words    = LEN_W'($urandom);
  endtask

  // Reference: word i is read from (s+4i) mod 2^11 and lands at (d+4i) mod 2^11.
  task automatic finishCheck(input string tag, input logic [10:0] s, input logic [10:0] d,
                             input int n, input int max_lat, input int exp_fill);
    int waited;
    logic [10:0] ra, wa;
    logic [31:0] sum;
    waited = 0;
    while (done_cnt == 0 && waited < max_lat + 100) begin
      @(negedge clock);
      waited++;
    end
    total++;
    if (done_cnt == 0) begin
      bad++;
      $display("[TB] FAIL %s done_timeout: got no done_port expected one within %0d cycles", tag, max_lat);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      return;
    end
    repeat (3) @(negedge clock);
    total++;
    if (done_cyc - start_cyc > max_lat) begin
      bad++;
      $display("[TB] FAIL %s latency: got %0d expected <= %0d", tag, done_cyc - start_cyc, max_lat);
    end
    checkOutput({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    checkOutput({tag, " busy_after"}, 64'(busy), 64'd0);
    checkOutput({tag, " words_done"}, 64'(words_done), 64'(n));
    checkOutput({tag, " reads"}, 64'(rd_n), 64'(n));
    checkOutput({tag, " writes"}, 64'(wr_n), 64'(n));
    checkOutput({tag, " protocol"}, 64'(proto_err), 64'd0);
    if (n == 0) checkOutput({tag, " bus_idle"}, 64'(bus_cycles), 64'd0);
    if (exp_fill >= 0) checkOutput({tag, " buffer_filled"}, 64'(full_seen > 0), 64'(exp_fill));
    sum = 32'h0;
    for (int i = 0; i < n && i < LOG_MAX; i++) begin
      ra = s + 11'(4 * i);
      wa = d + 11'(4 * i);
      sum += rmem[ra[10:2]];
      checkOutput($sformatf("%s rd_addr[%0d]", tag, i), 64'(rd_log_addr[i]), 64'(ra));
      checkOutput($sformatf("%s wr_addr[%0d]", tag, i), 64'(wr_log_addr[i]), 64'(wa));
      checkOutput($sformatf("%s wr_data[%0d]", tag, i), 64'(wr_log_data[i]), 64'(rmem[ra[10:2]]));
    end
`ifdef CHECKSUM_EN
    checkOutput({tag, " checksum"}, 64'(checksum), 64'(sum));
`endif
  endtask

  typedef struct {
    logic [10:0] src;
    logic [10:0] dst;
    int          n;
    int          rdd;
    int          wrd;
    int          max_lat;
    int          exp_fill;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{11'h100, 11'h200, 4, 2, 1, 11, 0};
    vecs[1] = '{11'h040, 11'h080, 0, 2, 1, 1, 0};
    vecs[2] = '{11'h100, 11'h300, 6, 2, 4, 40, 1};
    vecs[3] = '{11'h7FC, 11'h010, 2, 2, 1, 7, 0};
    vecs[4] = '{11'h003, 11'h7FE, 3, 1, 1, 9, 0};
    vecs[5] = '{11'h020, 11'h600, 3, 3, 1, 20, 0};

    for (int i = 0; i < MEM_WORDS; i++) rmem[i] = $urandom;
    for (int i = 0; i < 4; i++) rmem[32'h40 + i] = 32'h1111_1111 * (i + 1);

    reset = 1'b1; start_port = 1'b0; src_addr = '0; dst_addr = '0; n_words = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done_port), 64'd0);
    checkOutput("reset words_done", 64'(words_done), 64'd0);
    checkOutput("reset oe_we", 64'({Mout_oe_ram, Mout_we_ram}), 64'd0);
    checkOutput("reset addr", 64'(Mout_addr_ram), 64'd0);
    checkOutput("reset size", 64'(Mout_data_ram_size), 64'd0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].src, vecs[v].dst, vecs[v].n, vecs[v].rdd, vecs[v].wrd);
      finishCheck($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].n,
                  vecs[v].max_lat, vecs[v].exp_fill);
    end

    for (int r = 0; r < 8; r++) begin
      logic [10:0] s, d;
      int n, rdd, wrd;
      s   = 11'($urandom);
      d   = 11'($urandom);
      n   = $urandom_range(1, 12);
      rdd = $urandom_range(1, 4);
      wrd = $urandom_range(1, 4);
      applyStimulus(s, d, n, rdd, wrd);
      finishCheck($sformatf("rand%0d", r), s, d, n, n * (rdd + wrd) + 4, -1);
    end

    // A second start while running must be ignored.
    applyStimulus(11'h100, 11'h500, 5, 2, 2);
    repeat (3) @(negedge clock);
    src_addr = 11'h7F0; n_words = 16'd2; start_port = 1'b1;
    @(negedge clock);
    start_port = 1'b0;
    finishCheck("restart_ignored", 11'h100, 11'h500, 5, 40, -1);

    // Reset while word 3 is being read aborts with no done pulse.
    applyStimulus(11'h100, 11'h200, 8, 2, 1);
    for (int w = 0; w < 50 && rd_n < 2; w++) @(negedge clock);
    checkOutput("abort reached word3", 64'(rd_n), 64'd2);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort oe_we", 64'({Mout_oe_ram, Mout_we_ram}), 64'd0);
    checkOutput("abort addr", 64'(Mout_addr_ram), 64'd0);
    checkOutput("abort wdata", 64'(Mout_Wdata_ram), 64'd0);
    checkOutput("abort size", 64'(Mout_data_ram_size), 64'd0);
    checkOutput("abort busy_done", 64'({busy, done_port}), 64'd0);
    checkOutput("abort words_done", 64'(words_done), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("abort no_done", 64'(done_cnt), 64'd0);
    checkOutput("abort idle", 64'({busy, Mout_oe_ram, Mout_we_ram}), 64'd0);
    applyStimulus(11'h180, 11'h280, 1, 2, 1);
    finishCheck("after_abort", 11'h180, 11'h280, 1, 5, 0);

`ifdef CHECKSUM_EN
    rmem[32'h100] = 32'h0000_0001;
    rmem[32'h101] = 32'h0000_0002;
    rmem[32'h102] = 32'hFFFF_FFFF;
    applyStimulus(11'h400, 11'h040, 3, 2, 1);
    finishCheck("checksum_wrap", 11'h400, 11'h040, 3, 9, 0);
    checkOutput("checksum value", 64'(checksum), 64'h0000_0002);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
